// File: rtl/aes_decrypt_if.sv
// ---------------------------------------------------------------------------
// aes_decrypt_if
// Handshake and data bundle for the AES-128 inverse cipher core.
//   start       request, sampled only while the core is idle
//   key         128-bit cipher key, byte 0 at [127:120]
//   ciphertext  128-bit input block, byte 0 at [127:120]
//   plaintext   128-bit result register, updated only on completion
//   busy        high while an operation is in progress
//   done        one-cycle pulse marking a fresh plaintext
// master: the block source/sink side; slave: the aes_decrypt core.
// ---------------------------------------------------------------------------
interface aes_decrypt_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;

    modport master (
        output start, key, ciphertext,
        input  plaintext, busy, done
    );

    modport slave (
        input  start, key, ciphertext,
        output plaintext, busy, done
    );
endinterface

// File: rtl/aes_decrypt.sv
// ---------------------------------------------------------------------------
// aes_decrypt
// Iterative AES-128 inverse cipher, one round per clock. The forward key
// schedule is run first (10 cycles) to reach the round-10 key, then ten
// inverse rounds run while the key schedule is unwound on the fly.
// Latency: 20 cycles from the accepting edge to done.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    aes_decrypt_if.slave (start/key/ciphertext in,
//          plaintext/busy/done out)
// ---------------------------------------------------------------------------
module aes_decrypt (
    input  logic          clk,
    input  logic          rst_n,
    aes_decrypt_if.slave  bus
);

    // Byte 0 of each table sits in the most significant byte, so the lookup
    // index is the bitwise complement of the input byte.
    localparam logic [255:0][7:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Byte k of a block is element k (byte 0 = bits [127:120]).
    typedef logic [0:15][7:0] blk_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        DEC    = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_T[~b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_T[~b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One column through the 0e/0b/0d/09 circulant, built from x2/x4/x8
    // xtime chains so no general GF multiplier is needed.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    state_t       state;
    state_t       state_nxt;

    logic [127:0] rk;
    logic [127:0] ct;
    logic [127:0] st;
    logic [127:0] pt_q;
    logic [3:0]   cnt;
    logic         done_q;

    logic         do_load;
    logic         do_keyexp;
    logic         do_dec;
    logic         do_finish;
    logic         busy_c;

    // ---------------- key path ----------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  a1, a2, a3;
    logic [31:0]  sub_in;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [3:0]   rcon_idx;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    // Inverse step recovers words 3..1 by XORing neighbours; word 0 then
    // needs SubWord(RotWord) of the recovered word 3.
    assign a3 = w3 ^ w2;
    assign a2 = w2 ^ w1;
    assign a1 = w1 ^ w0;

    // The four S-boxes are shared: forward step feeds w3, inverse feeds a3.
    assign sub_in   = (state == DEC) ? a3 : w3;
    assign rot_w    = {sub_in[23:0], sub_in[31:24]};
    assign sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                       sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    // Unwinding from rk_i uses the Rcon that produced rk_i, i.e. cnt+1.
    assign rcon_idx = (state == DEC) ? cnt + 4'd1 : cnt;
    assign t_w      = sub_w ^ {rcon(rcon_idx), 24'h000000};

    assign f0     = w0 ^ t_w;
    assign f1     = w1 ^ f0;
    assign f2     = w2 ^ f1;
    assign f3     = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};
    assign rk_inv = {w0 ^ t_w, a1, a2, a3};

    // ---------------- state path ----------------
    blk_t st_b;
    blk_t sr_b;
    blk_t ark_b;
    blk_t mix_b;
    blk_t dec_b;

    assign st_b = st;

    // InvShiftRows shifts row r right by r, so output column c takes row r
    // from input column c-r; InvSubBytes is folded into the same loop.
    always_comb begin
        sr_b = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[4*c+r] = inv_sbox(st_b[4*((c-r+4)%4)+r]);
            end
        end
    end

    assign ark_b = sr_b ^ rk_inv;

    always_comb begin
        mix_b = '0;
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c +: 4] = inv_mix_col(ark_b[4*c +: 4]);
        end
    end

    // The final round has no InvMixColumns.
    assign dec_b = (cnt == 4'd0) ? ark_b : mix_b;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)     state_nxt = KEYEXP;
            KEYEXP:  if (cnt == 4'd10)  state_nxt = DEC;
            DEC:     if (cnt == 4'd0)   state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_load   = 1'b0;
        do_keyexp = 1'b0;
        do_dec    = 1'b0;
        do_finish = 1'b0;
        busy_c    = 1'b0;
        case (state)
            IDLE: begin
                do_load = bus.start;
            end
            KEYEXP: begin
                do_keyexp = 1'b1;
                busy_c    = 1'b1;
            end
            DEC: begin
                do_dec    = 1'b1;
                do_finish = (cnt == 4'd0);
                busy_c    = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk     <= '0;
            ct     <= '0;
            st     <= '0;
            pt_q   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= do_finish;
            if (do_load) begin
                rk  <= bus.key;
                ct  <= bus.ciphertext;
                cnt <= 4'd1;
            end
            if (do_keyexp) begin
                rk <= rk_fwd;
                if (cnt == 4'd10) begin
                    st  <= ct ^ rk_fwd;
                    cnt <= 4'd9;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
            if (do_dec) begin
                rk <= rk_inv;
                st <= dec_b;
                if (cnt == 4'd0) begin
                    pt_q <= dec_b;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt
// Directed and randomized bench for aes_decrypt. The reference model builds
// the S-boxes from GF(2^8) inversion plus the affine map, expands the whole
// key schedule up front, and runs the textbook inverse cipher on byte arrays.
// ---------------------------------------------------------------------------
module tb_aes_decrypt;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    aes_decrypt_if bus ();

    aes_decrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sboxes();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) begin
                inv = 8'h00;
            end else begin
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k,
                                                 input logic [127:0] c);
        logic [31:0]  w   [44];
        logic [7:0]   s   [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] rkr;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rc, sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        rkr = {w[40], w[41], w[42], w[43]};
        for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ rkr[127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int cc = 0; cc < 4; cc++)
                for (int rr = 0; rr < 4; rr++)
                    tmp[4*((cc+rr)%4)+rr] = isb[s[4*cc+rr]];
            rkr = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int i = 0; i < 16; i++) s[i] = tmp[i] ^ rkr[127-8*i -: 8];
            if (r > 0) begin
                for (int cc = 0; cc < 4; cc++) begin
                    tmp[0] = s[4*cc];   tmp[1] = s[4*cc+1];
                    tmp[2] = s[4*cc+2]; tmp[3] = s[4*cc+3];
                    s[4*cc]   = gmul(tmp[0],8'h0e)^gmul(tmp[1],8'h0b)^gmul(tmp[2],8'h0d)^gmul(tmp[3],8'h09);
                    s[4*cc+1] = gmul(tmp[0],8'h09)^gmul(tmp[1],8'h0e)^gmul(tmp[2],8'h0b)^gmul(tmp[3],8'h0d);
                    s[4*cc+2] = gmul(tmp[0],8'h0d)^gmul(tmp[1],8'h09)^gmul(tmp[2],8'h0e)^gmul(tmp[3],8'h0b);
                    s[4*cc+3] = gmul(tmp[0],8'h0b)^gmul(tmp[1],8'h0d)^gmul(tmp[2],8'h09)^gmul(tmp[3],8'h0e);
                end
            end
        end
        out = '0;
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises start for exactly one edge; returns 1 time unit after that edge.
    task automatic launch(input logic [127:0] k, input logic [127:0] c);
        bus.key        = k;
        bus.ciphertext = c;
        bus.start      = 1'b1;
        tick(1);
        bus.start      = 1'b0;
    endtask

    // lat counts edges since the accepting edge; bounded at 40.
    task automatic wait_done(input int from, output int lat, output bit ok);
        lat = from;
        ok  = 1'b0;
        while (!ok && lat < 40) begin
            tick(1);
            lat++;
            if (bus.done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic finish_checks(input string tag, input int lat, input bit ok,
                                 input logic [127:0] exp);
        check({tag, "_done_seen"}, 128'(ok), 128'd1);
        check({tag, "_latency"}, 128'(lat), 128'd20);
        check({tag, "_busy_fall"}, 128'(bus.busy), 128'd0);
        check({tag, "_pt"}, bus.plaintext, exp);
    endtask

    task automatic run_vec(input string tag, input logic [127:0] k,
                           input logic [127:0] c, input logic [127:0] exp);
        int lat;
        bit ok;
        launch(k, c);
        wait_done(0, lat, ok);
        finish_checks(tag, lat, ok, exp);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat;
        bit           ok;
        int           pulses;
        logic [127:0] k1, c1, k2, c2, exp, held;

        build_sboxes();

        // ---------------- reset ----------------
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.key        = rand128();
        bus.ciphertext = rand128();
        tick(2);
        rst_n = 1'b1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_pt", bus.plaintext, 128'd0);
        check("rst_rk", dut.rk, 128'd0);
        tick(1);

        // ---------------- FIPS-197 C.1 ----------------
        run_vec("c1", C1_KEY, C1_CT, C1_PT);
        tick(1);
        check("c1_done_pulse", 128'(bus.done), 128'd0);

        // ---------------- FIPS-197 App. B, key schedule endpoint ----------------
        launch(B_KEY, B_CT);
        tick(10);
        check("b_rk10", dut.rk, B_RK10);
        check("b_busy_mid", 128'(bus.busy), 128'd1);
        wait_done(10, lat, ok);
        finish_checks("b", lat, ok, B_PT);
        tick(1);

        // ---------------- zero key, then back-to-back C.1 ----------------
        run_vec("zero", 128'd0, Z_CT, 128'd0);
        // start is raised inside the done cycle; 20 more edges gives a
        // 21-cycle spacing between done pulses.
        run_vec("b2b", C1_KEY, C1_CT, C1_PT);
        tick(1);

        // ---------------- start while busy ----------------
        k1 = rand128(); c1 = rand128();
        k2 = rand128(); c2 = rand128();
        exp = ref_decrypt(k1, c1);
        launch(k1, c1);
        tick(4);
        bus.key        = k2;
        bus.ciphertext = c2;
        bus.start      = 1'b1;
        tick(1);
        bus.start      = 1'b0;
        wait_done(5, lat, ok);
        finish_checks("busy_start", lat, ok, exp);
        pulses = 0;
        repeat (30) begin
            tick(1);
            if (bus.done === 1'b1) pulses++;
        end
        check("busy_start_extra_done", 128'(pulses), 128'd0);
        check("busy_start_idle", 128'(bus.busy), 128'd0);

        // ---------------- reset mid-operation ----------------
        launch(C1_KEY, C1_CT);
        tick(13);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rstmid_busy", 128'(bus.busy), 128'd0);
        check("rstmid_done", 128'(bus.done), 128'd0);
        check("rstmid_pt", bus.plaintext, 128'd0);
        pulses = 0;
        repeat (30) begin
            tick(1);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        check("rstmid_no_late_done", 128'(pulses), 128'd0);
        check("rstmid_pt_held", bus.plaintext, 128'd0);
        run_vec("rstmid_rerun", C1_KEY, C1_CT, C1_PT);
        tick(1);

        // ---------------- randomized blocks against the model ----------------
        for (int n = 0; n < 8; n++) begin
            k1 = rand128();
            c1 = rand128();
            run_vec($sformatf("rand%0d", n), k1, c1, ref_decrypt(k1, c1));
            tick($urandom_range(0, 2));
        end

        // ---------------- hold ----------------
        tick(1);
        held = bus.plaintext;
        for (int n = 0; n < 50; n++) begin
            bus.key        = rand128();
            bus.ciphertext = rand128();
            tick(1);
            check("hold_pt", bus.plaintext, held);
            check("hold_busy_done", {126'd0, bus.busy, bus.done}, 128'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
